mag_window_stats: RTL and testbench
===================================

MAG_WINDOW_STATS -- requirements
Module: mag_window_stats

Interface
REQ-001 Parameter DATA_W, default 8: magnitude sample width.
REQ-002 Parameter ALARM_HI, default 200: alarm set threshold (used only with MAG_ALARM_EN).
REQ-003 Parameter ALARM_LO, default 150: alarm clear threshold (used only with MAG_ALARM_EN).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  block enable; when low, state and outputs hold.
REQ-007 mag_in  input  DATA_W  magnitude sample produced by the upstream magnitude stage.
REQ-008 mag_valid  input  1  mag_in is valid this cycle.
REQ-009 win_sel  input  2  window length: 0=8, 1=16, 2=32, 3=64 samples.
REQ-010 out_sel  input  2  result select: 0=max, 1=min, 2=average, 3=window count.
REQ-011 res_out  output  DATA_W  selected result.
REQ-012 res_valid  output  1  one-cycle pulse when a new window result is stored.
REQ-013 busy  output  1  high while a window is partially filled.
REQ-014 alarm  output  1  hysteresis alarm on window maximum.

Function
REQ-015 A sample is accepted only in a cycle where ena=1 and mag_valid=1; other cycles leave all counters and accumulators unchanged.
REQ-016 FSM states: IDLE, ACCUM, DONE.
- IDLE: accepted sample -> ACCUM.
- ACCUM: Nth accepted sample -> DONE.
- DONE: lasts exactly one cycle -> IDLE, or -> ACCUM if a sample is accepted in that cycle.
REQ-017 win_sel is latched when the first sample of a window is accepted; changes mid-window have no effect until the next window.
REQ-018 The first sample of a window initialises sum, max and min to that sample and sets the sample counter to 1.
REQ-019 Each subsequent accepted sample adds to the sum, updates max/min, and increments the counter.
REQ-020 The sum is DATA_W+6 bits wide and never overflows.
REQ-021 Average = sum >> log2(N), truncated, DATA_W bits.
REQ-022 The result registers (max, min, avg) load in the cycle after the Nth sample is accepted; res_valid is high for exactly that cycle (state DONE).
REQ-023 Window count is an 8-bit register incremented on each completed window; it wraps from 255 to 0.
REQ-024 Result registers hold their values until the next window completes.
REQ-025 res_out is a combinational mux of the held result registers selected by out_sel; a change in out_sel is reflected in the same cycle.
REQ-026 busy = 1 in ACCUM, 0 otherwise.
REQ-027 A sample accepted in the DONE cycle becomes the first sample of the next window, so no samples are lost when samples arrive back to back.

Reset
REQ-028 Asserting rst_n low clears all of the following asynchronously, including mid-window, and the partial window is discarded:
- FSM to IDLE;
- counter, sum, max, min, avg and window count to 0;
- res_out, res_valid, busy and alarm to 0.

Configuration
REQ-029 Macro MAG_ALARM_EN defined:
- at each window completion, alarm sets if window max >= ALARM_HI;
- alarm clears if window max <= ALARM_LO;
- otherwise alarm holds its value;
- alarm updates in the same cycle as res_valid.
REQ-030 Macro MAG_ALARM_EN undefined: alarm is tied to 0 and no threshold logic is present.

Structure
REQ-031 Package mag_stats_pkg holds the FSM state enum, the window-length lookup (win_sel to N and to log2 N), the accumulator width constant, and the out_sel encodings.
REQ-032 Sub-module mag_win_accum holds the sample counter, sum, max and min datapath; the top level holds the FSM, result registers, output mux and alarm.

Verification
REQ-033 win_sel=0, eight consecutive samples 10,20,...,80 -> res_valid pulses one cycle after 80 is accepted; max=80, min=10, avg=45, count=1.
REQ-034 win_sel=3, 64 samples of 255 -> avg=255, sum=16320 with no overflow; a 65th sample of 7 accepted in the DONE cycle starts the next window with min=max=7.
REQ-035 win_sel=1; reset asserted after 5 samples -> all outputs 0 immediately; the next 16 samples form a full window with count=1.
REQ-036 win_sel=0; samples 1..8 interleaved with mag_valid=1 cycles having ena=0 and mag_in=255 -> max=8, avg=4.
REQ-037 MAG_ALARM_EN defined; successive window maxima 210, 180, 140 -> alarm becomes 1, stays 1, then becomes 0.
REQ-038 win_sel changed from 0 to 2 after the 3rd sample of a window -> that window completes at 8 samples; the following window needs 32 samples.

Source files
------------

// File: rtl/mag_stats_pkg.sv
// Shared types and constants for the windowed magnitude statistics block:
// FSM states, window-length lookup, accumulator sizing and result-select codes.
package mag_stats_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Headroom bits above DATA_W so that a 64-sample sum cannot overflow.
    localparam int SUM_EXTRA_W = 6;
    // Sample counter must be able to hold 64.
    localparam int CNT_W = 7;

    localparam logic [1:0] OUT_MAX   = 2'd0;
    localparam logic [1:0] OUT_MIN   = 2'd1;
    localparam logic [1:0] OUT_AVG   = 2'd2;
    localparam logic [1:0] OUT_COUNT = 2'd3;

    function automatic logic [2:0] win_log2(input logic [1:0] sel);
        return 3'd3 + {1'b0, sel};
    endfunction

    function automatic logic [CNT_W-1:0] win_len(input logic [2:0] log2n);
        return CNT_W'(1) << log2n;
    endfunction

endpackage

// File: rtl/mag_win_accum.sv
// Per-window datapath: sample counter, running sum, running max and min.
// The *_next outputs already include the sample accepted this cycle.
module mag_win_accum
    import mag_stats_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          accept,
    input  logic                          first,
    input  logic [DATA_W-1:0]             sample,
    output logic [CNT_W-1:0]              cnt,
    output logic [DATA_W+SUM_EXTRA_W-1:0] sum_next,
    output logic [DATA_W-1:0]             max_next,
    output logic [DATA_W-1:0]             min_next
);
    localparam int SUM_W = DATA_W + SUM_EXTRA_W;

    logic [CNT_W-1:0]  cnt_reg;
    logic [SUM_W-1:0]  sum_reg;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] min_reg;

    // The first sample of a window replaces, rather than merges with, old state.
    always_comb begin
        sum_next = SUM_W'(sample);
        max_next = sample;
        min_next = sample;
        if (!first) begin
            sum_next = sum_reg + SUM_W'(sample);
            max_next = (sample > max_reg) ? sample : max_reg;
            min_next = (sample < min_reg) ? sample : min_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            sum_reg <= '0;
            max_reg <= '0;
            min_reg <= '0;
        end else if (accept) begin
            cnt_reg <= first ? CNT_W'(1) : cnt_reg + CNT_W'(1);
            sum_reg <= sum_next;
            max_reg <= max_next;
            min_reg <= min_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/mag_window_stats.sv
// Windowed max/min/average/count of a magnitude stream with selectable window.
// Optional hysteresis alarm on the window maximum: define MAG_ALARM_EN.
module mag_window_stats
    import mag_stats_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ALARM_HI = 200,
    parameter int ALARM_LO = 150
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] mag_in,
    input  logic              mag_valid,
    input  logic [1:0]        win_sel,
    input  logic [1:0]        out_sel,
    output logic [DATA_W-1:0] res_out,
    output logic              res_valid,
    output logic              busy,
    output logic              alarm
);
    localparam int SUM_W = DATA_W + SUM_EXTRA_W;

    state_t            state_reg;
    logic [2:0]        log2n_reg;
    logic [DATA_W-1:0] max_reg;
    logic [DATA_W-1:0] min_reg;
    logic [DATA_W-1:0] avg_reg;
    logic [7:0]        win_cnt_reg;
    logic              res_valid_reg;

    logic              accept;
    logic              first;
    logic              complete;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  sum_next;
    logic [DATA_W-1:0] max_next;
    logic [DATA_W-1:0] min_next;

    assign accept   = ena & mag_valid;
    // Any sample accepted outside ACCUM (including in DONE) opens a new window.
    assign first    = (state_reg != ACCUM);
    assign complete = accept && !first && (cnt + CNT_W'(1) == win_len(log2n_reg));

    mag_win_accum #(
        .DATA_W (DATA_W)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .accept   (accept),
        .first    (first),
        .sample   (mag_in),
        .cnt      (cnt),
        .sum_next (sum_next),
        .max_next (max_next),
        .min_next (min_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            log2n_reg     <= '0;
            max_reg       <= '0;
            min_reg       <= '0;
            avg_reg       <= '0;
            win_cnt_reg   <= '0;
            res_valid_reg <= 1'b0;
        end else if (ena) begin
            res_valid_reg <= 1'b0;
            if (accept && first)
                log2n_reg <= win_log2(win_sel);
            unique case (state_reg)
                IDLE: begin
                    if (accept)
                        state_reg <= ACCUM;
                end
                ACCUM: begin
                    if (complete) begin
                        state_reg     <= DONE;
                        res_valid_reg <= 1'b1;
                        max_reg       <= max_next;
                        min_reg       <= min_next;
                        avg_reg       <= DATA_W'(sum_next >> log2n_reg);
                        win_cnt_reg   <= win_cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= accept ? ACCUM : IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        res_out = max_reg;
        unique case (out_sel)
            OUT_MAX:   res_out = max_reg;
            OUT_MIN:   res_out = min_reg;
            OUT_AVG:   res_out = avg_reg;
            OUT_COUNT: res_out = DATA_W'(win_cnt_reg);
            default:   res_out = max_reg;
        endcase
    end

    assign res_valid = res_valid_reg;
    assign busy      = (state_reg == ACCUM);

`ifdef MAG_ALARM_EN
    localparam logic [DATA_W-1:0] HI_TH = DATA_W'(ALARM_HI);
    localparam logic [DATA_W-1:0] LO_TH = DATA_W'(ALARM_LO);

    logic alarm_reg;

    // Evaluated on the completing sample so it changes together with res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_reg <= 1'b0;
        end else if (ena && complete) begin
            if (max_next >= HI_TH)
                alarm_reg <= 1'b1;
            else if (max_next <= LO_TH)
                alarm_reg <= 1'b0;
        end
    end

    assign alarm = alarm_reg;
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats with hand-computed window results.
module tb_mag_window_stats;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] mag_in;
    logic       mag_valid;
    logic [1:0] win_sel;
    logic [1:0] out_sel;
    logic [7:0] res_out;
    logic       res_valid;
    logic       busy;
    logic       alarm;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef MAG_ALARM_EN
    localparam bit ALARM_ON = 1'b1;
`else
    localparam bit ALARM_ON = 1'b0;
`endif

    mag_window_stats #(
        .DATA_W   (8),
        .ALARM_HI (200),
        .ALARM_LO (150)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mag_in    (mag_in),
        .mag_valid (mag_valid),
        .win_sel   (win_sel),
        .out_sel   (out_sel),
        .res_out   (res_out),
        .res_valid (res_valid),
        .busy      (busy),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        ena       = 1'b1;
        mag_valid = 1'b1;
        mag_in    = v;
        tick();
        mag_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ena       = 1'b1;
            mag_valid = 1'b0;
            tick();
        end
    endtask

    task automatic expect_res(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                              input logic [7:0] av, input logic [7:0] ct);
        out_sel = 2'd0; #1; check({tag, "_max"}, res_out, mx);
        out_sel = 2'd1; #1; check({tag, "_min"}, res_out, mn);
        out_sel = 2'd2; #1; check({tag, "_avg"}, res_out, av);
        out_sel = 2'd3; #1; check({tag, "_cnt"}, res_out, ct);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; mag_in = '0; mag_valid = 1'b0;
        win_sel = 2'd0; out_sel = 2'd0;
        repeat (3) tick();
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_alarm", alarm, 0);
        expect_res("rst", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // 8-sample window 10..80
        win_sel = 2'd0;
        for (int i = 1; i <= 7; i++) send(8'(i * 10));
        check("w8_busy_mid", busy, 1);
        check("w8_valid_early", res_valid, 0);
        send(8'd80);
        check("w8_valid", res_valid, 1);
        check("w8_busy_done", busy, 0);
        expect_res("w8", 80, 10, 45, 1);
        idle(1);
        check("w8_valid_drop", res_valid, 0);
        idle(2);
        expect_res("w8_hold", 80, 10, 45, 1);

        // 64 x 255, then 7 accepted in DONE opens the next window
        win_sel = 2'd3;
        for (int i = 0; i < 64; i++) send(8'd255);
        check("w64_valid", res_valid, 1);
        expect_res("w64", 255, 255, 255, 2);
        send(8'd7);
        check("w64_b2b_busy", busy, 1);
        check("w64_b2b_valid", res_valid, 0);
        for (int i = 0; i < 63; i++) send(8'd100);
        check("w64b_valid", res_valid, 1);
        expect_res("w64b", 100, 7, 98, 3);

        // reset in the middle of a 16-sample window
        idle(1);
        win_sel = 2'd1;
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("w16_busy_pre_rst", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_alarm", alarm, 0);
        expect_res("mid_rst", 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) send(8'(i));
        check("w16_valid_early", res_valid, 0);
        send(8'd16);
        check("w16_valid", res_valid, 1);
        expect_res("w16", 16, 1, 8, 1);

        // ena=0 cycles carrying 255 must be ignored
        idle(2);
        win_sel = 2'd0;
        for (int i = 1; i <= 8; i++) begin
            ena = 1'b0; mag_valid = 1'b1; mag_in = 8'd255;
            tick();
            send(8'(i));
        end
        check("ena_valid", res_valid, 1);
        expect_res("ena", 8, 1, 4, 2);

        // win_sel change mid-window applies only to the next window
        idle(2);
        win_sel = 2'd0;
        for (int i = 0; i < 3; i++) send(8'd100);
        win_sel = 2'd2;
        for (int i = 0; i < 4; i++) send(8'd100);
        check("wsel_valid_7", res_valid, 0);
        send(8'd100);
        check("wsel_valid_8", res_valid, 1);
        expect_res("wsel8", 100, 100, 100, 3);
        idle(1);
        for (int i = 0; i < 31; i++) send(8'd50);
        check("wsel32_valid_31", res_valid, 0);
        check("wsel32_busy_31", busy, 1);
        send(8'd50);
        check("wsel32_valid", res_valid, 1);
        expect_res("wsel32", 50, 50, 50, 4);

        // alarm hysteresis on window maxima 210, 180, 140
        win_sel = 2'd0;
        idle(1);
        for (int i = 0; i < 8; i++) send(8'd210);
        check("alarm_210", alarm, ALARM_ON ? 1 : 0);
        idle(1);
        for (int i = 0; i < 8; i++) send(8'd180);
        check("alarm_180", alarm, ALARM_ON ? 1 : 0);
        idle(1);
        for (int i = 0; i < 8; i++) send(8'd140);
        check("alarm_140", alarm, 0);
        idle(3);
        check("final_valid", res_valid, 0);
        expect_res("final", 140, 140, 140, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
